// File: rtl/seg7_scan_reader.sv
// Reads a multiplexed seven-segment bus back into per-digit hex values with a valid/ready update stream.
// Define SEG7_ACTIVE_LOW_EN for common-anode boards (segment and strobe pins inverted at the input).
module seg7_scan_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2:0]              out_idx,
    output logic [3:0]              out_value,
    output logic                    out_err,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, TRACK, EMIT, HOLD} state_t;

    state_t                  state, state_n;
    logic [6:0]              seg_pin, seg_p0, seg_p1;
    logic [NUM_DIGITS-1:0]   sel_pin, sel_p0, sel_p1;
    logic [6:0]              cap_seg, cap_seg_n;
    logic [NUM_DIGITS-1:0]   cap_sel, cap_sel_n;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic                    load_out, accept;
    logic                    same, sel_ok, cur_dv;
    logic [4:0]              cap_dec;
    logic [3:0]              cur_digit;

`ifdef SEG7_ACTIVE_LOW_EN
    assign seg_pin = ~seg_in;
    assign sel_pin = ~dig_sel;
`else
    assign seg_pin = seg_in;
    assign sel_pin = dig_sel;
`endif

    // {err, value}; value forced to 0 for unknown patterns
    function automatic logic [4:0] decode7(input logic [6:0] s);
        case (s)
            7'h3F: return 5'h00;  7'h06: return 5'h01;
            7'h5B: return 5'h02;  7'h4F: return 5'h03;
            7'h66: return 5'h04;  7'h6D: return 5'h05;
            7'h7D: return 5'h06;  7'h07: return 5'h07;
            7'h7F: return 5'h08;  7'h6F: return 5'h09;
            7'h77: return 5'h0A;  7'h7C: return 5'h0B;
            7'h39: return 5'h0C;  7'h5E: return 5'h0D;
            7'h79: return 5'h0E;  7'h71: return 5'h0F;
            default: return 5'h10;
        endcase
    endfunction

    function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] v);
        int n = 0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (v[i]) n++;
        return (n == 1);
    endfunction

    function automatic logic [2:0] onehot_idx(input logic [NUM_DIGITS-1:0] v);
        logic [2:0] r = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (v[i]) r = 3'(i);
        return r;
    endfunction

    // Input stage: two-flop synchronizers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            seg_p0 <= '0;
            seg_p1 <= '0;
            sel_p0 <= '0;
            sel_p1 <= '0;
        end else begin
            seg_p0 <= seg_pin;
            seg_p1 <= seg_p0;
            sel_p0 <= sel_pin;
            sel_p1 <= sel_p0;
        end
    end

    assign same    = (sel_p1 == cap_sel) && (seg_p1 == cap_seg);
    assign sel_ok  = is_onehot(sel_p1);
    assign cap_dec = decode7(cap_seg);
    assign cur_dv  = |(digit_valid & cap_sel);

    always_comb begin
        cur_digit = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (cap_sel[i]) cur_digit = digits[4*i +: 4];
    end

    always_comb begin
        state_n   = state;
        cap_sel_n = cap_sel;
        cap_seg_n = cap_seg;
        cnt_n     = cnt;
        load_out  = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (sel_ok) begin
                    cap_sel_n = sel_p1;
                    cap_seg_n = seg_p1;
                    cnt_n     = CNT_W'(1);
                    state_n   = TRACK;
                end
            end
            TRACK, HOLD: begin
                if (!same) begin
                    if (sel_ok) begin
                        cap_sel_n = sel_p1;
                        cap_seg_n = seg_p1;
                        cnt_n     = CNT_W'(1);
                        state_n   = TRACK;
                    end else begin
                        cnt_n   = '0;
                        state_n = IDLE;
                    end
                end else if (state == TRACK) begin
                    if (cnt == CNT_W'(STABLE_CYCLES)) begin
                        // Re-reporting an unchanged valid digit is suppressed
                        if (cap_dec[4] || !cur_dv || (cap_dec[3:0] != cur_digit)) begin
                            load_out = 1'b1;
                            state_n  = EMIT;
                        end else begin
                            state_n = HOLD;
                        end
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    accept  = 1'b1;
                    state_n = HOLD;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign out_valid = (state == EMIT);

    // Control/capture stage and update registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            cap_sel     <= '0;
            cap_seg     <= '0;
            cnt         <= '0;
            out_idx     <= '0;
            out_value   <= '0;
            out_err     <= 1'b0;
            digits      <= '0;
            digit_valid <= '0;
        end else begin
            state   <= state_n;
            cap_sel <= cap_sel_n;
            cap_seg <= cap_seg_n;
            cnt     <= cnt_n;
            if (load_out) begin
                out_idx   <= onehot_idx(cap_sel);
                out_value <= cap_dec[3:0];
                out_err   <= cap_dec[4];
            end
            if (accept && !out_err) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (3'(i) == out_idx) begin
                        digits[4*i +: 4] <= out_value;
                        digit_valid[i]   <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
